// File: rtl/leaf_fifo_feeder.sv
// Write-side front end of the merger tree: slices a sorted stream into runs and deals them round-robin into per-leaf FWFT FIFOs.
// Optional run terminators (a 32'h0 word after each run) are enabled by defining LEAF_FEEDER_TERM_EN.
module leaf_fifo_feeder #(
  parameter int L       = 2,
  parameter int RUN_LEN = 4,
  parameter int DEPTH   = 8,
  localparam int NL     = 2 * L,
  localparam int SEL_W  = (NL > 1) ? $clog2(NL) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [NL-1:0]        i_fifo_read,
  output logic [32*NL-1:0]     o_fifo,
  output logic [NL-1:0]        o_fifo_empty,
  output logic [SEL_W-1:0]     o_leaf_sel,
  output logic                 o_run_done
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RC_W   = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;

`ifdef LEAF_FEEDER_TERM_EN
  typedef enum logic {ST_DATA, ST_TERM} state_t;
  state_t state_q, state_d;
`endif

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [RC_W-1:0]   wcnt_q, wcnt_d;
  logic              run_done_q, run_done_d;
  logic [NL-1:0]     primed_q, primed_d;
  logic [CNT_W-1:0]  cnt_q [NL];
  logic [CNT_W-1:0]  cnt_d [NL];
  logic [PTR_W-1:0]  wr_ptr_q [NL];
  logic [PTR_W-1:0]  wr_ptr_d [NL];
  logic [PTR_W-1:0]  rd_ptr_q [NL];
  logic [PTR_W-1:0]  rd_ptr_d [NL];
  logic [DATA_W-1:0] mem_q [NL][DEPTH];

  logic [NL-1:0]     full, empty, wr_en, rd_en;
  logic [DATA_W-1:0] wr_data;
  logic              write, accept, last_word, leaf_full;

  function automatic logic [SEL_W-1:0] next_leaf(input logic [SEL_W-1:0] s);
    return (s == SEL_W'(NL - 1)) ? '0 : s + SEL_W'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NL; k++) begin
      full[k]  = (cnt_q[k] == CNT_W'(DEPTH));
      empty[k] = (cnt_q[k] == '0);
    end
  end

  assign leaf_full = full[sel_q];
  assign last_word = (wcnt_q == RC_W'(RUN_LEN - 1));

  // Run sequencing: word counter, leaf selection and run-done pulse
`ifdef LEAF_FEEDER_TERM_EN
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    wcnt_d     = wcnt_q;
    run_done_d = 1'b0;
    wr_data    = i_data;
    o_ready    = ~leaf_full & (state_q == ST_DATA);
    accept     = i_valid & o_ready;
    write      = accept;
    case (state_q)
      ST_DATA: begin
        if (accept) begin
          if (last_word) begin
            wcnt_d  = '0;
            state_d = ST_TERM;
          end else begin
            wcnt_d = wcnt_q + RC_W'(1);
          end
        end
      end
      ST_TERM: begin
        // The terminator waits for space in the same leaf the run went to
        if (!leaf_full) begin
          write      = 1'b1;
          wr_data    = '0;
          sel_d      = next_leaf(sel_q);
          run_done_d = 1'b1;
          state_d    = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase
  end
`else
  always_comb begin
    sel_d      = sel_q;
    wcnt_d     = wcnt_q;
    run_done_d = 1'b0;
    wr_data    = i_data;
    o_ready    = ~leaf_full;
    accept     = i_valid & o_ready;
    write      = accept;
    if (accept) begin
      if (last_word) begin
        wcnt_d     = '0;
        sel_d      = next_leaf(sel_q);
        run_done_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + RC_W'(1);
      end
    end
  end
`endif

  // Per-leaf FIFO bookkeeping; reads on an empty leaf are dropped here
  always_comb begin
    o_fifo = '0;
    for (int k = 0; k < NL; k++) begin
      wr_en[k]    = write & (sel_q == SEL_W'(k));
      rd_en[k]    = i_fifo_read[k] & ~empty[k];
      cnt_d[k]    = cnt_q[k];
      wr_ptr_d[k] = wr_ptr_q[k];
      rd_ptr_d[k] = rd_ptr_q[k];
      primed_d[k] = primed_q[k] | wr_en[k];
      if (wr_en[k] && !rd_en[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end else if (!wr_en[k] && rd_en[k]) begin
        cnt_d[k] = cnt_q[k] - CNT_W'(1);
      end
      if (wr_en[k]) begin
        wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(1);
      end
      if (rd_en[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(1);
      end
      // Storage is not reset, so a leaf shows zero until it is first written
      o_fifo[DATA_W*k +: DATA_W] = primed_q[k] ? mem_q[k][rd_ptr_q[k]] : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sel_q      <= '0;
      wcnt_q     <= '0;
      run_done_q <= 1'b0;
      primed_q   <= '0;
      for (int k = 0; k < NL; k++) begin
        cnt_q[k]    <= '0;
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
      end
`ifdef LEAF_FEEDER_TERM_EN
      state_q    <= ST_DATA;
`endif
    end else begin
      sel_q      <= sel_d;
      wcnt_q     <= wcnt_d;
      run_done_q <= run_done_d;
      primed_q   <= primed_d;
      for (int k = 0; k < NL; k++) begin
        cnt_q[k]    <= cnt_d[k];
        wr_ptr_q[k] <= wr_ptr_d[k];
        rd_ptr_q[k] <= rd_ptr_d[k];
      end
`ifdef LEAF_FEEDER_TERM_EN
      state_q    <= state_d;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NL; k++) begin
      if (wr_en[k] && i_rst_n) begin
        mem_q[k][wr_ptr_q[k]] <= wr_data;
      end
    end
  end

  assign o_fifo_empty = empty;
  assign o_leaf_sel   = sel_q;
  assign o_run_done   = run_done_q;

endmodule

// File: tb/tb_leaf_fifo_feeder.sv
// Directed bench for leaf_fifo_feeder with L=2, RUN_LEN=2, DEPTH=4 (four leaves of four entries).
module tb_leaf_fifo_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  data;
  logic         valid;
  logic         ready;
  logic [3:0]   rd;
  logic [127:0] fifo;
  logic [3:0]   empty;
  logic [1:0]   sel;
  logic         done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  leaf_fifo_feeder #(.L(2), .RUN_LEN(2), .DEPTH(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data       (data),
    .i_valid      (valid),
    .o_ready      (ready),
    .i_fifo_read  (rd),
    .o_fifo       (fifo),
    .o_fifo_empty (empty),
    .o_leaf_sel   (sel),
    .o_run_done   (done)
  );

  typedef struct {
    logic         r;
    logic         v;
    logic [31:0]  d;
    logic [3:0]   rd;
    logic         rdy;
    logic [3:0]   emp;
    logic [1:0]   sel;
    logic         done;
    logic         chkf;
    logic [127:0] f;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // One clock: drive on the falling edge, return 1 time unit after the rising edge
  task automatic cyc(input logic r, input logic v, input logic [31:0] d, input logic [3:0] rr);
    @(negedge clk);
    rst_n = r; valid = v; data = d; rd = rr;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] head(input int k);
    return fifo[32*k +: 32];
  endfunction

  vec_t tv [13];

  initial begin
    rst_n = 1'b0; valid = 1'b0; data = '0; rd = '0;

`ifndef LEAF_FEEDER_TERM_EN
    tv[0]  = '{1'b0, 1'b0, 32'd0, 4'b0000, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b1, 128'd0};
    tv[1]  = '{1'b1, 1'b1, 32'd1, 4'b0000, 1'b1, 4'b1110, 2'd0, 1'b0, 1'b0, 128'd0};
    tv[2]  = '{1'b1, 1'b1, 32'd2, 4'b0000, 1'b1, 4'b1110, 2'd1, 1'b1, 1'b1, 128'd1};
    tv[3]  = '{1'b1, 1'b1, 32'd3, 4'b0000, 1'b1, 4'b1100, 2'd1, 1'b0, 1'b0, 128'd0};
    tv[4]  = '{1'b1, 1'b1, 32'd4, 4'b0000, 1'b1, 4'b1100, 2'd2, 1'b1, 1'b0, 128'd0};
    tv[5]  = '{1'b1, 1'b1, 32'd5, 4'b0000, 1'b1, 4'b1000, 2'd2, 1'b0, 1'b0, 128'd0};
    tv[6]  = '{1'b1, 1'b1, 32'd6, 4'b0000, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0, 128'd0};
    tv[7]  = '{1'b1, 1'b1, 32'd7, 4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 128'd0};
    tv[8]  = '{1'b1, 1'b1, 32'd8, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b1,
               {32'd7, 32'd5, 32'd3, 32'd1}};
    tv[9]  = '{1'b1, 1'b0, 32'd0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1,
               {32'd7, 32'd5, 32'd3, 32'd1}};
    tv[10] = '{1'b1, 1'b0, 32'd0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b1,
               {32'd8, 32'd6, 32'd4, 32'd2}};
    tv[11] = '{1'b1, 1'b0, 32'd0, 4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 128'd0};
    tv[12] = '{1'b1, 1'b0, 32'd0, 4'b1111, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 128'd0};

    // Round-robin fill of 1..8, then drain every leaf, then over-read
    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].r, tv[i].v, tv[i].d, tv[i].rd);
      chk($sformatf("v%0d_ready", i), 128'(ready), 128'(tv[i].rdy));
      chk($sformatf("v%0d_empty", i), 128'(empty), 128'(tv[i].emp));
      chk($sformatf("v%0d_sel", i),   128'(sel),   128'(tv[i].sel));
      chk($sformatf("v%0d_done", i),  128'(done),  128'(tv[i].done));
      if (tv[i].chkf) chk($sformatf("v%0d_fifo", i), fifo, tv[i].f);
    end

    // All leaves full, 17th word stalls until leaf0 is read once
    cyc(1'b0, 1'b0, 32'd0, 4'b0000);
    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b1, 32'(i), 4'b0000);
    chk("full_ready", 128'(ready), 128'(1'b0));
    chk("full_empty", 128'(empty), 128'(4'b0000));
    chk("full_sel",   128'(sel),   128'(2'd0));
    chk("full_heads", fifo, {32'd7, 32'd5, 32'd3, 32'd1});
    cyc(1'b1, 1'b1, 32'd17, 4'b0000);
    cyc(1'b1, 1'b1, 32'd17, 4'b0000);
    chk("stall_ready", 128'(ready), 128'(1'b0));
    chk("stall_head0", 128'(head(0)), 128'(32'd1));
    cyc(1'b1, 1'b1, 32'd17, 4'b0001);
    chk("freed_ready", 128'(ready), 128'(1'b1));
    chk("freed_head0", 128'(head(0)), 128'(32'd2));
    cyc(1'b1, 1'b1, 32'd17, 4'b0000);
    chk("w17_ready", 128'(ready), 128'(1'b0));
    chk("w17_sel",   128'(sel),   128'(2'd0));
    chk("w17_done",  128'(done),  128'(1'b0));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("drain0_a", 128'(head(0)), 128'(32'd9));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("drain0_b", 128'(head(0)), 128'(32'd10));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("drain0_c", 128'(head(0)), 128'(32'd17));
    chk("drain0_c_emp", 128'(empty[0]), 128'(1'b0));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("drain0_d_emp", 128'(empty[0]), 128'(1'b1));

    // Over-reading an empty leaf, then simultaneous read and write
    cyc(1'b0, 1'b0, 32'd0, 4'b0000);
    cyc(1'b1, 1'b1, 32'd10, 4'b0000);
    cyc(1'b1, 1'b1, 32'd20, 4'b0000);
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("rd1_head0", 128'(head(0)), 128'(32'd20));
    chk("rd1_emp0",  128'(empty[0]), 128'(1'b0));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("rd2_emp0",  128'(empty[0]), 128'(1'b1));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("rd3_emp0",  128'(empty[0]), 128'(1'b1));
    chk("rd3_ready", 128'(ready), 128'(1'b1));
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 32'(100 + i), 4'b0000);
    chk("wrap_sel", 128'(sel), 128'(2'd0));
    cyc(1'b1, 1'b1, 32'd30, 4'b0000);
    chk("w30_head0", 128'(head(0)), 128'(32'd30));
    chk("w30_emp0",  128'(empty[0]), 128'(1'b0));
    cyc(1'b1, 1'b1, 32'd40, 4'b0000);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 32'(200 + i), 4'b0000);
    cyc(1'b1, 1'b1, 32'd50, 4'b0001);
    chk("rw_head0", 128'(head(0)), 128'(32'd40));
    chk("rw_ready", 128'(ready), 128'(1'b1));
    chk("rw_sel",   128'(sel),   128'(2'd0));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("rw_tail",  128'(head(0)), 128'(32'd50));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("rw_drained", 128'(empty[0]), 128'(1'b1));

    // Reset in the middle of a run with a word pending
    cyc(1'b0, 1'b0, 32'd0, 4'b0000);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 32'(i), 4'b0000);
    chk("pre_rst_sel", 128'(sel), 128'(2'd2));
    cyc(1'b0, 1'b1, 32'd99, 4'b0000);
    chk("rst_empty", 128'(empty), 128'(4'b1111));
    chk("rst_sel",   128'(sel),   128'(2'd0));
    chk("rst_ready", 128'(ready), 128'(1'b1));
    chk("rst_done",  128'(done),  128'(1'b0));
    chk("rst_fifo",  fifo, 128'd0);
    cyc(1'b1, 1'b1, 32'd77, 4'b0000);
    chk("post_rst_empty", 128'(empty), 128'(4'b1110));
    chk("post_rst_head0", 128'(head(0)), 128'(32'd77));
    chk("post_rst_sel",   128'(sel), 128'(2'd0));
    cyc(1'b1, 1'b1, 32'd78, 4'b0000);
    chk("post_rst_sel2",  128'(sel), 128'(2'd1));
    chk("post_rst_done",  128'(done), 128'(1'b1));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("post_rst_next",  128'(head(0)), 128'(32'd78));
`else
    // Terminated runs: 1,2 then 0 into leaf0; 3 into leaf1
    cyc(1'b0, 1'b0, 32'd0, 4'b0000);
    chk("rst_empty", 128'(empty), 128'(4'b1111));
    chk("rst_ready", 128'(ready), 128'(1'b1));
    chk("rst_fifo",  fifo, 128'd0);
    cyc(1'b1, 1'b1, 32'd1, 4'b0000);
    chk("t1_ready", 128'(ready), 128'(1'b1));
    chk("t1_sel",   128'(sel),   128'(2'd0));
    cyc(1'b1, 1'b1, 32'd2, 4'b0000);
    chk("t2_ready", 128'(ready), 128'(1'b0));
    chk("t2_sel",   128'(sel),   128'(2'd0));
    chk("t2_done",  128'(done),  128'(1'b0));
    cyc(1'b1, 1'b1, 32'd3, 4'b0000);
    chk("term_ready", 128'(ready), 128'(1'b1));
    chk("term_sel",   128'(sel),   128'(2'd1));
    chk("term_done",  128'(done),  128'(1'b1));
    chk("term_emp1",  128'(empty[1]), 128'(1'b1));
    cyc(1'b1, 1'b1, 32'd3, 4'b0000);
    chk("t3_emp1",  128'(empty[1]), 128'(1'b0));
    chk("t3_head1", 128'(head(1)), 128'(32'd3));
    chk("t3_done",  128'(done), 128'(1'b0));
    cyc(1'b1, 1'b0, 32'd0, 4'b0000);
    chk("l0_a", 128'(head(0)), 128'(32'd1));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("l0_b", 128'(head(0)), 128'(32'd2));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("l0_c", 128'(head(0)), 128'(32'd0));
    chk("l0_c_emp", 128'(empty[0]), 128'(1'b0));
    cyc(1'b1, 1'b0, 32'd0, 4'b0001);
    chk("l0_d_emp", 128'(empty[0]), 128'(1'b1));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
